// File: rtl/mmio_bridge_n.sv
// MMIO bridge: NUM_DEV device slots plus a control slot (INT_PENDING/INT_MASK/ERR_ADDR/ERR_CLR); MMIO_BRIDGE_INT_EDGE_EN selects edge/W1C pending.
// Latency: strobe one cycle after the request edge, pr_ready the cycle after that; the CPU holds its request until pr_ready.
module mmio_bridge_n #(
    parameter int NUM_DEV   = 3,
    parameter int SLOT_LO   = 7,
    parameter int BASE_PAGE = 'h7F,
    parameter int NUM_INT   = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [29:0]           pr_addr,
    input  logic [31:0]           pr_wd,
    input  logic [3:0]            pr_be,
    input  logic                  pr_we,
    input  logic                  pr_re,
    output logic [31:0]           pr_rd,
    output logic                  pr_ready,
    output logic [SLOT_LO-2:0]    dev_addr,
    output logic [31:0]           dev_wd,
    output logic [3:0]            dev_be,
    output logic [NUM_DEV-1:0]    dev_we,
    output logic [NUM_DEV-1:0]    dev_re,
    input  logic [32*NUM_DEV-1:0] dev_rd,
    input  logic [NUM_INT-1:0]    dev_int,
    output logic [5:0]            hw_int
);
    localparam int OW = SLOT_LO - 1;
    localparam int PW = 31 - SLOT_LO;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t               state_q;
    logic [29:0]          addr_q;
    logic                 we_q;
    logic [NUM_DEV-1:0]   hit_q;
    logic                 ctl_q;
    logic                 unm_q;
    logic [31:0]          wd_q;
    logic [3:0]           be_q;
    logic [NUM_DEV-1:0]   dev_we_q;
    logic [NUM_DEV-1:0]   dev_re_q;
    logic                 ready_q;
    logic [31:0]          rd_q;
    logic [NUM_INT-1:0]   mask_q;
    logic [NUM_INT-1:0]   pend_q;
    logic [5:0]           hw_int_q;
    logic                 err_valid_q;
    logic [29:0]          err_addr_q;

    logic [PW-1:0]        page;
    logic [NUM_DEV-1:0]   hit_d;
    logic                 ctl_d;
    logic [OW-1:0]        ofs;
    logic [31:0]          rd_cap;
    logic                 wr_ctl;
    logic                 err_set;
    logic                 err_clr;

    always_comb begin
        page  = pr_addr[29:OW];
        hit_d = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            hit_d[k] = (page == PW'(BASE_PAGE + k));
        end
        ctl_d = (page == PW'(BASE_PAGE + NUM_DEV));
    end

    assign ofs = addr_q[OW-1:0];

    always_comb begin
        rd_cap = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            if (hit_q[k]) rd_cap = rd_cap | dev_rd[32*k +: 32];
        end
        if (ctl_q) begin
            case (ofs)
                OW'(0):  rd_cap = 32'(pend_q);
                OW'(1):  rd_cap = 32'(mask_q);
                OW'(2):  rd_cap = {err_addr_q, 1'b0, err_valid_q};
                default: rd_cap = '0;
            endcase
        end
    end

    // Control-slot side effects and error capture all happen in the ACCESS cycle.
    assign wr_ctl  = (state_q == ACCESS) && ctl_q && we_q;
    assign err_clr = wr_ctl && (ofs == OW'(3));
    assign err_set = (state_q == ACCESS) && unm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            hit_q    <= '0;
            ctl_q    <= 1'b0;
            unm_q    <= 1'b0;
            wd_q     <= '0;
            be_q     <= '0;
            dev_we_q <= '0;
            dev_re_q <= '0;
            ready_q  <= 1'b0;
            rd_q     <= '0;
        end else begin
            dev_we_q <= '0;
            dev_re_q <= '0;
            ready_q  <= 1'b0;
            rd_q     <= '0;
            case (state_q)
                IDLE: begin
                    if (pr_we || pr_re) begin
                        addr_q   <= pr_addr;
                        wd_q     <= pr_wd;
                        be_q     <= pr_be;
                        we_q     <= pr_we;
                        hit_q    <= hit_d;
                        ctl_q    <= ctl_d;
                        unm_q    <= ~(|hit_d) & ~ctl_d;
                        dev_we_q <= pr_we ? hit_d : '0;
                        dev_re_q <= pr_we ? '0 : hit_d;
                        state_q  <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready_q <= 1'b1;
                    rd_q    <= we_q ? 32'h0 : rd_cap;
                    state_q <= RESP;
                end
                RESP:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Set beats clear so a capture is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            err_valid_q <= (err_valid_q & ~err_clr) | err_set;
            if (err_set) err_addr_q <= addr_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q   <= '1;
            hw_int_q <= '0;
        end else begin
            if (wr_ctl && (ofs == OW'(1)) && be_q[0]) mask_q <= wd_q[NUM_INT-1:0];
            hw_int_q <= 6'(pend_q & mask_q);
        end
    end

`ifdef MMIO_BRIDGE_INT_EDGE_EN
    logic [NUM_INT-1:0] dint_q;
    logic [NUM_INT-1:0] pend_clr;

    assign pend_clr = (wr_ctl && (ofs == OW'(0)) && be_q[0]) ? wd_q[NUM_INT-1:0] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dint_q <= '0;
            pend_q <= '0;
        end else begin
            dint_q <= dev_int;
            pend_q <= (pend_q & ~pend_clr) | (dev_int & ~dint_q);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= dev_int;
    end
`endif

    assign pr_rd    = rd_q;
    assign pr_ready = ready_q;
    assign dev_addr = addr_q[OW-1:0];
    assign dev_wd   = wd_q;
    assign dev_be   = be_q;
    assign dev_we   = dev_we_q;
    assign dev_re   = dev_re_q;
    assign hw_int   = hw_int_q;
endmodule

// File: tb/tb_mmio_bridge_n.sv
// Bench for mmio_bridge_n: directed cases then random traffic against a queue scoreboard.
module tb_mmio_bridge_n;
    localparam int ND   = 3;
    localparam int BASE = 'h7F;

    typedef struct {
        logic [2:0]  we;
        logic [2:0]  re;
        logic [5:0]  ofs;
        logic [31:0] wd;
        logic [3:0]  be;
    } stb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [29:0] pr_addr = '0;
    logic [31:0] pr_wd = '0;
    logic [3:0]  pr_be = '0;
    logic        pr_we = 1'b0;
    logic        pr_re = 1'b0;
    logic [31:0] pr_rd;
    logic        pr_ready;
    logic [5:0]  dev_addr;
    logic [31:0] dev_wd;
    logic [3:0]  dev_be;
    logic [2:0]  dev_we;
    logic [2:0]  dev_re;
    logic [95:0] dev_rd = '0;
    logic [5:0]  dev_int = '0;
    logic [5:0]  hw_int;

    always #5 clk = ~clk;

    mmio_bridge_n #(.NUM_DEV(ND), .SLOT_LO(7), .BASE_PAGE(BASE), .NUM_INT(6)) dut (
        .clk(clk), .rst_n(rst_n), .pr_addr(pr_addr), .pr_wd(pr_wd), .pr_be(pr_be),
        .pr_we(pr_we), .pr_re(pr_re), .pr_rd(pr_rd), .pr_ready(pr_ready),
        .dev_addr(dev_addr), .dev_wd(dev_wd), .dev_be(dev_be), .dev_we(dev_we),
        .dev_re(dev_re), .dev_rd(dev_rd), .dev_int(dev_int), .hw_int(hw_int)
    );

    int n_chk = 0;
    int n_fail = 0;
    stb_t        stb_q[$];
    logic [31:0] rsp_q[$];

    // Reference state of the bridge registers.
    logic [5:0]  mask_m = 6'h3F;
    logic [5:0]  pend_m = 6'h00;
    logic        err_v_m = 1'b0;
    logic [29:0] err_a_m = '0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    function automatic logic [5:0] hw_m();
        return pend_m & mask_m;
    endfunction

    function automatic logic [29:0] mk_addr(input int page, input int off);
        logic [23:0] p;
        logic [5:0]  o;
        p = 24'(page);
        o = 6'(off);
        return {p, o};
    endfunction

    initial begin : monitor
        stb_t        s;
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (dev_we != 3'b0 || dev_re != 3'b0) begin
                    if (stb_q.size() == 0) begin
                        chk("spurious_strobe", {26'b0, dev_we, dev_re}, 32'h0);
                    end else begin
                        s = stb_q.pop_front();
                        chk("dev_we", 32'(dev_we), 32'(s.we));
                        chk("dev_re", 32'(dev_re), 32'(s.re));
                        chk("dev_addr", 32'(dev_addr), 32'(s.ofs));
                        chk("dev_wd", dev_wd, s.wd);
                        chk("dev_be", 32'(dev_be), 32'(s.be));
                    end
                end
                if (pr_ready) begin
                    if (rsp_q.size() == 0) begin
                        chk("spurious_ready", 32'(pr_ready), 32'h0);
                    end else begin
                        e = rsp_q.pop_front();
                        chk("pr_rd", pr_rd, e);
                    end
                end
            end
        end
    end

    task automatic access(input logic w, input logic r, input logic [29:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        int          page;
        int          off;
        int          n;
        bit          got;
        logic [31:0] exp;
        logic [5:0]  hw0;
        stb_t        s;
        page = int'(a >> 6);
        off  = int'(a & 30'h3F);
        hw0  = hw_m();
        exp  = 32'h0;
        if (page >= BASE && page < BASE + ND) begin
            s.we  = w ? 3'(1 << (page - BASE)) : 3'b0;
            s.re  = w ? 3'b0 : 3'(1 << (page - BASE));
            s.ofs = 6'(off);
            s.wd  = d;
            s.be  = b;
            stb_q.push_back(s);
            if (!w) exp = dev_rd[32*(page-BASE) +: 32];
        end else if (page == BASE + ND) begin
            if (w) begin
                if (off == 1 && b[0]) mask_m = d[5:0];
                if (off == 3) err_v_m = 1'b0;
`ifdef MMIO_BRIDGE_INT_EDGE_EN
                if (off == 0 && b[0]) pend_m = pend_m & ~d[5:0];
`endif
            end else begin
                case (off)
                    0:       exp = 32'(pend_m);
                    1:       exp = 32'(mask_m);
                    2:       exp = {err_a_m, 1'b0, err_v_m};
                    default: exp = 32'h0;
                endcase
            end
        end else begin
            err_v_m = 1'b1;
            err_a_m = a;
        end
        rsp_q.push_back(exp);

        @(negedge clk);
        pr_addr = a; pr_wd = d; pr_be = b; pr_we = w; pr_re = r;
        @(posedge clk);
        n = 0;
        got = 0;
        while (!got && n < 8) begin
            @(negedge clk);
            n++;
            if (pr_ready) got = 1;
        end
        pr_we = 1'b0;
        pr_re = 1'b0;
        chk("ready_latency", 32'(n), 32'd2);
        chk("hw_int_at_resp", 32'(hw_int), 32'(hw0));
        @(negedge clk);
        chk("hw_int_after", 32'(hw_int), 32'(hw_m()));
    endtask

    task automatic set_int(input logic [5:0] v);
        @(negedge clk);
`ifdef MMIO_BRIDGE_INT_EDGE_EN
        pend_m = pend_m | (v & ~dev_int);
`else
        pend_m = v;
`endif
        dev_int = v;
        repeat (3) @(negedge clk);
        chk("hw_int_settled", 32'(hw_int), 32'(hw_m()));
    endtask

    initial begin : main
        int          sel;
        int          page;
        int          off;
        logic        w;
        logic        r;
        logic [31:0] d;

        @(negedge clk);
        chk("rst_pr_ready", 32'(pr_ready), 32'h0);
        chk("rst_pr_rd", pr_rd, 32'h0);
        chk("rst_strobes", {26'b0, dev_we, dev_re}, 32'h0);
        chk("rst_dev_addr", 32'(dev_addr), 32'h0);
        chk("rst_hw_int", 32'(hw_int), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        access(1'b0, 1'b1, mk_addr(BASE + ND, 1), 32'h0, 4'h0);
        dev_rd[63:32] = 32'hDEADBEEF;
        access(1'b0, 1'b1, mk_addr(BASE + 1, 3), 32'h0, 4'h0);
        access(1'b1, 1'b0, mk_addr(BASE + 2, 0), 32'h12345678, 4'b0011);
        access(1'b0, 1'b1, mk_addr('h90, 5), 32'h0, 4'h0);
        access(1'b0, 1'b1, mk_addr(BASE + ND, 2), 32'h0, 4'h0);
        access(1'b1, 1'b0, mk_addr(BASE + ND, 3), 32'h0, 4'hF);
        access(1'b0, 1'b1, mk_addr(BASE + ND, 2), 32'h0, 4'h0);

        // Interrupt path latency and mask.
        @(negedge clk);
        dev_int = 6'h01;
        pend_m  = 6'h01;
        @(negedge clk);
        chk("int_one_cycle", 32'(hw_int), 32'h0);
        @(negedge clk);
        chk("int_two_cycles", 32'(hw_int), 32'h01);
        access(1'b1, 1'b0, mk_addr(BASE + ND, 1), 32'h3E, 4'h1);

        // Single-cycle pulse on dev_int[3].
        @(negedge clk);
        dev_int = 6'h09;
        @(negedge clk);
        dev_int = 6'h01;
        @(negedge clk);
        chk("pulse_hw_int", 32'(hw_int), 32'h08);
`ifdef MMIO_BRIDGE_INT_EDGE_EN
        pend_m = 6'h09;
`else
        pend_m = 6'h01;
`endif
        @(negedge clk);
        chk("pulse_after", 32'(hw_int), 32'(hw_m()));
        access(1'b0, 1'b1, mk_addr(BASE + ND, 0), 32'h0, 4'h0);
        access(1'b1, 1'b0, mk_addr(BASE + ND, 0), 32'h08, 4'h1);
        access(1'b0, 1'b1, mk_addr(BASE + ND, 0), 32'h0, 4'h0);

        // Reset in the middle of an ACCESS cycle.
        set_int(6'h00);
        @(negedge clk);
        pr_addr = mk_addr(BASE, 7);
        pr_re   = 1'b1;
        @(posedge clk);
        #2;
        chk("mid_access_strobe", 32'(dev_re), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_strobe", {26'b0, dev_we, dev_re}, 32'h0);
        chk("abort_ready", 32'(pr_ready), 32'h0);
        pr_re = 1'b0;
        mask_m = 6'h3F; pend_m = 6'h00; err_v_m = 1'b0; err_a_m = '0;
        @(negedge clk);
        chk("abort_ready_hold", 32'(pr_ready), 32'h0);
        rst_n = 1'b1;
        dev_rd[31:0] = 32'hCAFEF00D;
        access(1'b0, 1'b1, mk_addr(BASE, 7), 32'h0, 4'h0);
        access(1'b0, 1'b1, mk_addr(BASE + ND, 1), 32'h0, 4'h0);

        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) set_int(6'($urandom));
            if ($urandom_range(0, 7) == 0) begin
                @(negedge clk);
                dev_rd = {$urandom, $urandom, $urandom};
            end
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2: page = BASE + sel;
                3:       page = BASE + ND;
                4:       page = int'($urandom_range(0, 'hFFFFFF));
                default: page = $urandom_range(0, 1) ? BASE - 1 : BASE + ND + 1;
            endcase
            off = (sel == 3) ? $urandom_range(0, 5) : $urandom_range(0, 63);
            w = 1'($urandom_range(0, 1));
            r = w ? 1'($urandom_range(0, 1)) : 1'b1;
            d = $urandom;
            access(w, r, mk_addr(page, off), d, 4'($urandom));
        end

        repeat (3) @(negedge clk);
        chk("stb_queue_empty", 32'(stb_q.size()), 32'h0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_bridge_n.md
Name: mmio_bridge_n

Overview:
- Parametrised CPU-to-device MMIO bridge, successor to the fixed three-device bridge.
- Decodes the CPU word address into NUM_DEV device slots plus one bridge-internal control slot.
- Runs a 3-state request/response FSM with a pr_ready handshake instead of a free-running combinational read path.
- Aggregates device interrupts into hw_int[7:2] through a mask register and an error-capture register.

Parameters:
- NUM_DEV, 3: device slots, legal 1..7.
- SLOT_LO, 7: slot k is hit when pr_addr[31:SLOT_LO+1] == BASE_PAGE+k; devices receive pr_addr[SLOT_LO:2].
- BASE_PAGE, 'h7F: page index of slot 0. The control slot is BASE_PAGE+NUM_DEV.
- NUM_INT, 6: interrupt lines in use, legal 1..6; mapped to hw_int[2+i].

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pr_addr  in  30  CPU word address [31:2]
- pr_wd  in  32  CPU write data
- pr_be  in  4  byte enables
- pr_we  in  1  write request
- pr_re  in  1  read request
- pr_rd  out  32  read data, valid while pr_ready=1
- pr_ready  out  1  one-cycle completion pulse
- dev_addr  out  SLOT_LO-1  device offset, registered
- dev_wd  out  32  registered write data
- dev_be  out  4  registered byte enables
- dev_we  out  NUM_DEV  one-hot write strobe
- dev_re  out  NUM_DEV  one-hot read strobe
- dev_rd  in  32*NUM_DEV  device read data; slot k at [32k+31:32k]
- dev_int  in  NUM_INT  device interrupt requests
- hw_int  out  6  CPU interrupt lines [7:2]; bits beyond NUM_INT tie to 0

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; INT_MASK all ones; pending 0; ERR_VALID 0; ERR_ADDR 0.
- Reset is asynchronous. Asserting it mid-transaction aborts the transaction: no strobe, no pr_ready.
- FSM IDLE: if pr_we|pr_re, register addr/wd/be/we and decode -> ACCESS. If pr_we and pr_re are both high, the access is a write.
- FSM ACCESS (exactly 1 cycle):
  - Assert dev_we[k] or dev_re[k] for the hit slot only.
  - Capture read data: dev_rd slot k, or the control register, or 0 if unmapped.
  - Go to RESP.
- FSM RESP (1 cycle): pr_ready=1 and pr_rd holds the captured data (0 for writes). Strobes are 0. Go to IDLE.
- Latency: request sampled at edge N, strobe in cycle N+1, pr_ready in cycle N+2. Back-to-back throughput is one access per 3 cycles.
- The CPU holds its request until it sees pr_ready. Requests presented outside IDLE are ignored.
- A request still high in the cycle after RESP starts a new transaction.
- Unmapped access (no device slot, no control slot):
  - No strobe; read returns 0; pr_ready still pulses.
  - ERR_ADDR latches the address; ERR_VALID is set. If the error is already valid, a newer unmapped access overwrites ERR_ADDR.
- Control slot offsets (word):
  - 0: INT_PENDING, RO.
  - 1: INT_MASK, RW. A write updates it only when pr_be[0]=1, using wd[NUM_INT-1:0].
  - 2: ERR_ADDR, RO; returns {ERR_ADDR[31:2],1'b0,ERR_VALID}.
  - 3: ERR_CLR, WO. Any write clears ERR_VALID.
  - Other offsets read 0 and ignore writes; they are not errors.
- If an unmapped access and an ERR_CLR write land in the same cycle, the set wins. This cannot occur with a single request stream; it is specified for the formal check.
- Interrupts: pending is updated every cycle from dev_int. hw_int[2+i] = registered (pending[i] & INT_MASK[i]).
- Interrupt latency: one cycle from pending to hw_int.
- A write to INT_MASK takes effect on hw_int 2 cycles after the ACCESS cycle.

Optional Feature:
- Macro: MMIO_BRIDGE_INT_EDGE_EN.
- Defined:
  - pending[i] sets on a rising edge of dev_int[i] (dev_int registered once for edge detect) and holds.
  - A write to INT_PENDING (offset 0) with pr_be[0]=1 clears bits written as 1 (W1C).
  - If set and clear coincide, the set wins.
- Undefined:
  - pending[i] = dev_int[i] registered (level); the INT_PENDING write is ignored.

Test Plan:
- Reset, then read slot 1 offset 3 (pr_addr = (BASE_PAGE+1)<<6 | 3) with dev_rd slot1='hDEADBEEF -> dev_re=3'b010 for one cycle; pr_ready 2 cycles after the request edge; pr_rd='hDEADBEEF.
- Write 'h12345678 to slot 2 with pr_be=4'b0011 -> dev_we=3'b100 one cycle; dev_wd='h12345678; dev_be=4'b0011; pr_rd=0 at pr_ready.
- Read address page 'h90 -> no strobe; pr_rd=0; control offset 2 reads {addr,1'b0,1'b1}; write offset 3 -> next read of offset 2 shows bit0=0.
- INT_MASK reset 'h3F; dev_int[0]=1 -> hw_int[2]=1 after 2 cycles. Write INT_MASK='h3E -> hw_int[2]=0 two cycles after ACCESS.
- Assert rst_n=0 during ACCESS -> strobes and pr_ready go 0 immediately; after release the FSM is IDLE and the next read completes normally.
- With MMIO_BRIDGE_INT_EDGE_EN: pulse dev_int[3] one cycle -> pending[3]=1 held. Write 'h08 to offset 0 -> pending[3]=0. Without the macro, the same pulse gives a 1-cycle hw_int[5] pulse.
